tlight_scheduler: RTL and testbench
===================================

Name: tlight_scheduler

Overview:
- Demand-actuated phase scheduler for one two-way intersection (NS and WE approaches) plus an all-red pedestrian phase.
- Latches vehicle-detector and pedestrian-button requests and arbitrates between them round-robin.
- Enforces minimum/maximum green, yellow and all-red clearance times; handles emergency-vehicle preemption.
- Drives the lamp outputs directly. Timing assumes the system 1 s clock.

Parameters:
- MIN_GREEN, 5: minimum green cycles before a green can be cut by a competing request.
- MAX_GREEN, 15: green cycles after which a green ends if a competing request is pending.
- YELLOW_TIME, 3: yellow cycles.
- ALLRED_TIME, 1: all-red clearance cycles.
- WALK_TIME, 8: pedestrian walk cycles.
- TW, 5: dwell-counter width; must hold max(all durations).

Ports:
- clock  input  1  system clock, rising edge, 1 s period
- reset_n  input  1  asynchronous active-low reset
- ns_req  input  1  NS vehicle detector; level sampled each cycle
- we_req  input  1  WE vehicle detector; level sampled each cycle
- ped_req  input  1  pedestrian button; level sampled each cycle
- emerg  input  1  emergency preemption active (level)
- emerg_dir  input  1  preempting direction: 0 = NS, 1 = WE; meaningful only while emerg = 1
- ns  output  3  NS lamp, one-hot {RED, YELLOW, GREEN} = 100 / 010 / 001
- we  output  3  WE lamp, same encoding
- walk  output  1  pedestrian walk lamp
- phase  output  3  current state code (see below), for monitoring

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- States and codes: ALL_RED = 0, WE_GO = 1, WE_YEL = 2, NS_GO = 3, NS_YEL = 4, PED_WALK = 5.
- Outputs are a Moore decode of state, with no extra latency:
  - ALL_RED and PED_WALK: ns = we = RED.
  - WE_GO: we = GREEN, ns = RED. WE_YEL: we = YELLOW, ns = RED.
  - NS_GO: ns = GREEN, we = RED. NS_YEL: ns = YELLOW, we = RED.
  - walk = 1 only in PED_WALK.
- Reset (async assert, any time, including mid-phase):
  - state = ALL_RED, dwell = 0, all pending flags = 0, last = PED.
  - Outputs become ns = we = RED, walk = 0, phase = 0 immediately.
- Dwell counter: cleared to 0 on every state change, otherwise increments; saturates at all-ones.
- Pending flags (ns_pend, we_pend, ped_pend):
  - Each is set when its request is sampled high.
  - A request is not latched while its own phase is active (NS_GO, WE_GO or PED_WALK respectively).
  - A flag is cleared on the cycle its phase is entered. Set and clear in the same cycle: clear wins.
- ALL_RED: exits when dwell == ALLRED_TIME-1. Next state, in priority order:
  - emerg = 1: go to the emerg_dir green.
  - Otherwise, the first pending phase in fixed rotation WE -> NS -> PED, starting after last.
  - Nothing pending: the green opposite to last (last = PED or NS gives WE_GO; last = WE gives NS_GO).
  - last is updated on green/walk entry.
- WE_GO / NS_GO:
  - emerg = 1 with emerg_dir = own direction: hold green regardless of dwell.
  - emerg = 1 with emerg_dir = other direction: go to own YEL next cycle, ignoring MIN_GREEN.
  - Otherwise, go to YEL when any competing flag is pending and dwell >= MIN_GREEN-1, or when competing is pending and dwell >= MAX_GREEN-1.
  - Competing flags: the other direction's flag or ped_pend.
  - No competing request: rest in green indefinitely.
- WE_YEL / NS_YEL: go to ALL_RED when dwell == YELLOW_TIME-1; emerg does not shorten yellow.
- PED_WALK: go to ALL_RED when dwell == WALK_TIME-1, or immediately (next cycle) if emerg = 1.
- Illegal state codes 6/7 recover to ALL_RED on the next clock.
- Safety invariant: ns and we are never both non-RED in the same cycle.

Test Plan:
- Release reset with no requests: ns = we = RED for 1 cycle, then WE_GO (we = 001) rests indefinitely. Assert ns_req at cycle 20: WE_YEL for 3 cycles, ALL_RED for 1 cycle, then NS_GO.
- WE_GO entered at cycle t, ns_req pulsed at t+1: WE_GO persists until dwell = 4, so we = 010 first appears at cycle t+5.
- ped_req and ns_req both pending during WE_GO: rotation serves NS_GO next, then PED_WALK. walk = 1 for exactly 8 cycles with ns = we = 100 throughout.
- NS_GO at dwell 1, emerg = 1 with emerg_dir = 1: NS_YEL next cycle, 3 yellow cycles, 1 all-red, then WE_GO held while emerg = 1 even with ns_req asserted.
- Deassert reset_n mid-PED_WALK between clock edges: walk = 0 and phase = 0 immediately; pending flags cleared; normal sequence resumes after release.
- Random requests plus emerg for 10k cycles: assert the one-hot lamp encoding, that both directions are never non-RED, that yellow lasts >= 3 cycles, and that every latched request is served within 2*(MAX_GREEN+YELLOW_TIME+ALLRED_TIME)+WALK_TIME cycles when emerg = 0.

Source files
------------

// File: rtl/tlight_scheduler.sv
// ---------------------------------------------------------------------------
// tlight_scheduler
//
// Demand-actuated phase scheduler for a two-way intersection (NS and WE
// approaches) plus an all-red pedestrian walk phase. Vehicle-detector and
// pedestrian-button requests are latched into pending flags. The pending
// flags are served in round-robin order, starting after the most recently
// served phase. Green phases honour minimum and maximum green times.
// Yellow and all-red clearance intervals always run their full length.
// Emergency preemption forces the requested direction to green as soon as
// it is safe to do so, and holds it there.
//
// Ports:
//   clock      system clock, rising edge (1 s period)
//   reset_n    asynchronous active-low reset
//   ns_req     NS vehicle detector, level sampled every cycle
//   we_req     WE vehicle detector, level sampled every cycle
//   ped_req    pedestrian push button, level sampled every cycle
//   emerg      emergency preemption active (level)
//   emerg_dir  preempting direction: 0 = NS, 1 = WE
//   ns         NS lamp, one-hot {RED, YELLOW, GREEN}
//   we         WE lamp, one-hot {RED, YELLOW, GREEN}
//   walk       pedestrian walk lamp
//   phase      current state code, for monitoring
// ---------------------------------------------------------------------------
module tlight_scheduler #(
  parameter int MIN_GREEN   = 5,
  parameter int MAX_GREEN   = 15,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 8,
  parameter int TW          = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ns_req,
  input  logic       we_req,
  input  logic       ped_req,
  input  logic       emerg,
  input  logic       emerg_dir,
  output logic [2:0] ns,
  output logic [2:0] we,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ALL_RED  = 3'd0,
    WE_GO    = 3'd1,
    WE_YEL   = 3'd2,
    NS_GO    = 3'd3,
    NS_YEL   = 3'd4,
    PED_WALK = 3'd5
  } state_t;

  // Most recently served phase; this is the round-robin pointer.
  typedef enum logic [1:0] {
    LAST_WE  = 2'd0,
    LAST_NS  = 2'd1,
    LAST_PED = 2'd2
  } last_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // A dwell value equal to one of these means the current cycle is the
  // last cycle (or the threshold cycle) of the corresponding interval.
  localparam logic [TW-1:0] ALLRED_END = TW'(ALLRED_TIME - 1);
  localparam logic [TW-1:0] YELLOW_END = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] WALK_END   = TW'(WALK_TIME - 1);
  localparam logic [TW-1:0] MIN_END    = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_END    = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] DWELL_SAT  = {TW{1'b1}};

  state_t        state;
  state_t        state_next;
  state_t        rr_pick;
  last_t         last;
  last_t         last_next;
  logic [TW-1:0] dwell;
  logic [TW-1:0] dwell_next;
  logic          ns_pend;
  logic          we_pend;
  logic          ped_pend;
  logic          ns_pend_next;
  logic          we_pend_next;
  logic          ped_pend_next;
  logic          entering;
  logic          we_compete;
  logic          ns_compete;

  // Competing demand for each green: the cross direction or a pedestrian.
  assign we_compete = ns_pend | ped_pend;
  assign ns_compete = we_pend | ped_pend;

  // Round-robin choice for leaving ALL_RED. The scan order is
  // WE -> NS -> PED, and it starts just after the last served phase. With
  // no demand, the green opposite the last served one is chosen. After
  // PED, that green is WE.
  always_comb begin
    rr_pick = WE_GO;
    case (last)
      LAST_WE: begin
        if (ns_pend)       rr_pick = NS_GO;
        else if (ped_pend) rr_pick = PED_WALK;
        else if (we_pend)  rr_pick = WE_GO;
        else               rr_pick = NS_GO;
      end
      LAST_NS: begin
        if (ped_pend)      rr_pick = PED_WALK;
        else if (we_pend)  rr_pick = WE_GO;
        else if (ns_pend)  rr_pick = NS_GO;
        else               rr_pick = WE_GO;
      end
      default: begin
        if (we_pend)       rr_pick = WE_GO;
        else if (ns_pend)  rr_pick = NS_GO;
        else if (ped_pend) rr_pick = PED_WALK;
        else               rr_pick = WE_GO;
      end
    endcase
  end

  // Next-state logic. A green with no competing demand rests forever.
  // The max-green term is implied by the min-green term for sane
  // parameters. It is kept so that the intent stays visible.
  always_comb begin
    state_next = state;
    case (state)
      ALL_RED: begin
        if (dwell == ALLRED_END) begin
          if (emerg) state_next = emerg_dir ? WE_GO : NS_GO;
          else       state_next = rr_pick;
        end
      end
      WE_GO: begin
        if (emerg) begin
          if (!emerg_dir) state_next = WE_YEL;
        end else if (we_compete && ((dwell >= MIN_END) || (dwell >= MAX_END))) begin
          state_next = WE_YEL;
        end
      end
      WE_YEL: begin
        if (dwell == YELLOW_END) state_next = ALL_RED;
      end
      NS_GO: begin
        if (emerg) begin
          if (emerg_dir) state_next = NS_YEL;
        end else if (ns_compete && ((dwell >= MIN_END) || (dwell >= MAX_END))) begin
          state_next = NS_YEL;
        end
      end
      NS_YEL: begin
        if (dwell == YELLOW_END) state_next = ALL_RED;
      end
      PED_WALK: begin
        if (emerg || (dwell == WALK_END)) state_next = ALL_RED;
      end
      default: state_next = ALL_RED;
    endcase
  end

  assign entering = (state_next != state);

  // Request latching and bookkeeping. A request is ignored while its own
  // phase is being served. A flag is cleared on the edge that enters its
  // phase, and that clear overrides a request sampled on the same edge.
  always_comb begin
    ns_pend_next  = ns_pend  | (ns_req  & (state != NS_GO));
    we_pend_next  = we_pend  | (we_req  & (state != WE_GO));
    ped_pend_next = ped_pend | (ped_req & (state != PED_WALK));
    last_next     = last;
    if (entering) begin
      case (state_next)
        NS_GO: begin
          ns_pend_next = 1'b0;
          last_next    = LAST_NS;
        end
        WE_GO: begin
          we_pend_next = 1'b0;
          last_next    = LAST_WE;
        end
        PED_WALK: begin
          ped_pend_next = 1'b0;
          last_next     = LAST_PED;
        end
        default: ;
      endcase
    end
  end

  // The dwell counter restarts on every state change and saturates, so a
  // long resting green can never wrap back into the min-green window.
  always_comb begin
    dwell_next = dwell;
    if (entering)                dwell_next = '0;
    else if (dwell != DWELL_SAT) dwell_next = dwell + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ALL_RED;
      dwell    <= '0;
      ns_pend  <= 1'b0;
      we_pend  <= 1'b0;
      ped_pend <= 1'b0;
      last     <= LAST_PED;
    end else begin
      state    <= state_next;
      dwell    <= dwell_next;
      ns_pend  <= ns_pend_next;
      we_pend  <= we_pend_next;
      ped_pend <= ped_pend_next;
      last     <= last_next;
    end
  end

  // Moore lamp decode. Illegal codes show all red until the next edge
  // returns the FSM to ALL_RED.
  always_comb begin
    ns   = LAMP_RED;
    we   = LAMP_RED;
    walk = 1'b0;
    case (state)
      WE_GO:    we   = LAMP_GREEN;
      WE_YEL:   we   = LAMP_YELLOW;
      NS_GO:    ns   = LAMP_GREEN;
      NS_YEL:   ns   = LAMP_YELLOW;
      PED_WALK: walk = 1'b1;
      default:  ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_tlight_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tlight_scheduler
//
// Directed testbench for tlight_scheduler. Each scenario task drives
// cycle-indexed stimulus and compares the lamp and phase outputs against a
// hand-derived expected sequence. The random task checks lamp safety,
// yellow length and request service latency against a small bench-side
// model of request demand.
// ---------------------------------------------------------------------------
module tb_tlight_scheduler;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // The expected observation vector is {ns, we, walk, phase}.
  localparam logic [9:0] V_AR   = {RED, RED, 1'b0, 3'd0};
  localparam logic [9:0] V_WE   = {RED, GRN, 1'b0, 3'd1};
  localparam logic [9:0] V_WEY  = {RED, YEL, 1'b0, 3'd2};
  localparam logic [9:0] V_NS   = {GRN, RED, 1'b0, 3'd3};
  localparam logic [9:0] V_NSY  = {YEL, RED, 1'b0, 3'd4};
  localparam logic [9:0] V_PED  = {RED, RED, 1'b1, 3'd5};

  // The worst-case service bound is 2*(15+3+1)+8.
  localparam int SERVICE_BOUND = 46;

  logic       clock     = 1'b0;
  logic       reset_n   = 1'b0;
  logic       ns_req    = 1'b0;
  logic       we_req    = 1'b0;
  logic       ped_req   = 1'b0;
  logic       emerg     = 1'b0;
  logic       emerg_dir = 1'b0;
  logic [2:0] ns;
  logic [2:0] we;
  logic       walk;
  logic [2:0] phase;
  logic [9:0] obs;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  always #5 clock = ~clock;

  assign obs = {ns, we, walk, phase};

  tlight_scheduler dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ns_req    (ns_req),
    .we_req    (we_req),
    .ped_req   (ped_req),
    .emerg     (emerg),
    .emerg_dir (emerg_dir),
    .ns        (ns),
    .we        (we),
    .walk      (walk),
    .phase     (phase)
  );

  // Outputs are observed 1 time unit after the active edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // This task holds reset for two edges, then releases it between edges.
  // The cycle that follows the release is cycle 0 (ALL_RED).
  task automatic start_run();
    reset_n   = 1'b0;
    ns_req    = 1'b0;
    we_req    = 1'b0;
    ped_req   = 1'b0;
    emerg     = 1'b0;
    emerg_dir = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic push_exp(input logic [9:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    ns_req    = 1'b1;
    we_req    = 1'b1;
    ped_req   = 1'b1;
    emerg     = 1'b1;
    emerg_dir = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (obs !== V_AR) begin
        errors++;
        $display("[TB] FAIL reset cycle %0d: got %b expected %b", c, obs, V_AR);
      end
    end
    ns_req  = 1'b0;
    we_req  = 1'b0;
    ped_req = 1'b0;
    emerg   = 1'b0;
  endtask

  task automatic test_rest_and_switch();
    exp_q.delete();
    push_exp(V_AR, 1);
    push_exp(V_WE, 21);
    push_exp(V_WEY, 3);
    push_exp(V_AR, 1);
    push_exp(V_NS, 5);
    start_run();
    for (int c = 0; c < exp_q.size(); c++) begin
      ns_req = (c == 20);
      checks++;
      if (obs !== exp_q[c]) begin
        errors++;
        $display("[TB] FAIL rest_switch cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
      step();
    end
    ns_req = 1'b0;
  endtask

  task automatic test_min_green();
    exp_q.delete();
    push_exp(V_AR, 1);
    push_exp(V_WE, 5);
    push_exp(V_WEY, 3);
    push_exp(V_AR, 1);
    push_exp(V_NS, 3);
    start_run();
    for (int c = 0; c < exp_q.size(); c++) begin
      ns_req = (c == 2);
      checks++;
      if (obs !== exp_q[c]) begin
        errors++;
        $display("[TB] FAIL min_green cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
      step();
    end
    ns_req = 1'b0;
  endtask

  task automatic test_rotation_ped();
    exp_q.delete();
    push_exp(V_AR, 1);
    push_exp(V_WE, 5);
    push_exp(V_WEY, 3);
    push_exp(V_AR, 1);
    push_exp(V_NS, 5);
    push_exp(V_NSY, 3);
    push_exp(V_AR, 1);
    push_exp(V_PED, 8);
    push_exp(V_AR, 1);
    push_exp(V_WE, 1);
    start_run();
    for (int c = 0; c < exp_q.size(); c++) begin
      ns_req  = (c == 1);
      ped_req = (c == 1);
      checks++;
      if (obs !== exp_q[c]) begin
        errors++;
        $display("[TB] FAIL rotation_ped cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
      step();
    end
    ns_req  = 1'b0;
    ped_req = 1'b0;
  endtask

  task automatic test_emergency();
    exp_q.delete();
    push_exp(V_AR, 1);
    push_exp(V_WE, 5);
    push_exp(V_WEY, 3);
    push_exp(V_AR, 1);
    push_exp(V_NS, 2);
    push_exp(V_NSY, 3);
    push_exp(V_AR, 1);
    push_exp(V_WE, 11);
    push_exp(V_WEY, 1);
    start_run();
    emerg_dir = 1'b1;
    for (int c = 0; c < exp_q.size(); c++) begin
      ns_req = (c <= 26);
      emerg  = (c >= 11) && (c <= 25);
      checks++;
      if (obs !== exp_q[c]) begin
        errors++;
        $display("[TB] FAIL emergency cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
      step();
    end
    ns_req    = 1'b0;
    emerg     = 1'b0;
    emerg_dir = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_q.delete();
    push_exp(V_AR, 1);
    push_exp(V_WE, 5);
    push_exp(V_WEY, 3);
    push_exp(V_AR, 1);
    push_exp(V_NS, 5);
    push_exp(V_NSY, 3);
    push_exp(V_AR, 1);
    push_exp(V_PED, 3);
    start_run();
    // A fresh NS request is latched during the walk, so a reset that
    // failed to clear the flags would cut the following resting WE green.
    for (int c = 0; c < exp_q.size(); c++) begin
      ns_req  = (c == 1) || (c >= 20);
      ped_req = (c == 1);
      checks++;
      if (obs !== exp_q[c]) begin
        errors++;
        $display("[TB] FAIL async_pre cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
      step();
    end
    @(negedge clock);
    reset_n = 1'b0;
    ns_req  = 1'b0;
    #1;
    checks++;
    if (obs !== V_AR) begin
      errors++;
      $display("[TB] FAIL async_assert: got %b expected %b", obs, V_AR);
    end
    step();
    reset_n = 1'b1;
    exp_q.delete();
    push_exp(V_AR, 1);
    push_exp(V_WE, 10);
    for (int c = 0; c < exp_q.size(); c++) begin
      checks++;
      if (obs !== exp_q[c]) begin
        errors++;
        $display("[TB] FAIL async_post cycle %0d: got %b expected %b", c, obs, exp_q[c]);
      end
      step();
    end
  endtask

  task automatic test_random();
    bit waiting[3];
    int age[3];
    bit active[3];
    bit reqs[3];
    int yel_ns;
    int yel_we;
    bit lamps_ok;
    yel_ns = 0;
    yel_we = 0;
    for (int k = 0; k < 3; k++) begin
      waiting[k] = 1'b0;
      age[k]     = 0;
    end
    start_run();
    for (int c = 0; c < 10000; c++) begin
      ns_req    = ($urandom_range(7) == 0);
      we_req    = ($urandom_range(7) == 0);
      ped_req   = ($urandom_range(19) == 0);
      emerg     = ((c % 1000) >= 500) && ((c % 1000) < 530);
      emerg_dir = ((c / 1000) % 2) == 1;

      lamps_ok = $onehot(ns) && $onehot(we) && ((ns == RED) || (we == RED))
                 && (!walk || ((ns == RED) && (we == RED)));
      checks++;
      if (!lamps_ok) begin
        errors++;
        $display("[TB] FAIL lamps cycle %0d: got ns=%b we=%b walk=%b required one-hot, one side red",
                 c, ns, we, walk);
      end

      if (ns == YEL) yel_ns++;
      else if (yel_ns != 0) begin
        checks++;
        if (yel_ns != 3) begin
          errors++;
          $display("[TB] FAIL ns_yellow_len cycle %0d: got %0d required 3", c, yel_ns);
        end
        yel_ns = 0;
      end
      if (we == YEL) yel_we++;
      else if (yel_we != 0) begin
        checks++;
        if (yel_we != 3) begin
          errors++;
          $display("[TB] FAIL we_yellow_len cycle %0d: got %0d required 3", c, yel_we);
        end
        yel_we = 0;
      end

      // Index 0 = WE, 1 = NS, 2 = PED.
      active[0] = (we == GRN);
      active[1] = (ns == GRN);
      active[2] = walk;
      reqs[0]   = we_req;
      reqs[1]   = ns_req;
      reqs[2]   = ped_req;
      for (int k = 0; k < 3; k++)
        if (reqs[k] && !active[k]) waiting[k] = 1'b1;

      step();

      active[0] = (we == GRN);
      active[1] = (ns == GRN);
      active[2] = walk;
      for (int k = 0; k < 3; k++) begin
        if (active[k]) begin
          if (waiting[k]) begin
            checks++;
            if (age[k] > SERVICE_BOUND) begin
              errors++;
              $display("[TB] FAIL service_%0d cycle %0d: got %0d cycles required <= %0d",
                       k, c, age[k], SERVICE_BOUND);
            end
          end
          waiting[k] = 1'b0;
          age[k]     = 0;
        end else if (waiting[k]) begin
          if (emerg) age[k] = 0;
          else       age[k]++;
          if (age[k] > SERVICE_BOUND) begin
            checks++;
            errors++;
            $display("[TB] FAIL service_timeout_%0d cycle %0d: got %0d cycles required <= %0d",
                     k, c, age[k], SERVICE_BOUND);
            waiting[k] = 1'b0;
            age[k]     = 0;
          end
        end
      end
    end
    ns_req  = 1'b0;
    we_req  = 1'b0;
    ped_req = 1'b0;
    emerg   = 1'b0;
  endtask

  initial begin
    $display("[TB] tlight_scheduler bench start");
    test_reset();
    test_rest_and_switch();
    test_min_green();
    test_rotation_ped();
    test_emergency();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
